// File: rtl/pattern_pkg.sv
// Shared types and line-level constants for the 01-sync serial pattern transmitter.
package pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE0,
    PRE1,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic SYNC0     = 1'b0;
  localparam logic SYNC1     = 1'b1;

endpackage

// File: rtl/pattern_bit_timer.sv
// Symbol timer: counts CLKS_PER_BIT cycles per symbol and flags the last one.
module pattern_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam int W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [W-1:0] LAST     = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE_LAST = W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  logic [W-1:0] cnt;

  // pre_tick leads tick by one cycle so the owner can register last-cycle outputs
  assign tick     = en & (cnt == LAST);
  assign pre_tick = (CLKS_PER_BIT > 1) & en & (cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_tx.sv
// Frames a parallel word as 0,1 preamble + MSB-first payload + optional even parity + stop.
module pattern_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  import pattern_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic SINGLE_CLK = (CLKS_PER_BIT == 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              parity;
  logic              tick;
  logic              pre_tick;
  logic              accept;

  assign ready      = (state == IDLE);
  assign accept     = valid & ready;
  assign shreg_next = shreg << 1;

  pattern_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (state != IDLE),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // sout always holds the symbol of the state being entered, so it is glitch-free on the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      parity  <= 1'b0;
      sout    <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sout <= LINE_IDLE;
          if (valid) begin
            shreg   <= data;
            parity  <= ^data;
            bit_cnt <= '0;
            state   <= PRE0;
            sout    <= SYNC0;
            busy    <= 1'b1;
          end
        end
        PRE0: if (tick) begin
          state <= PRE1;
          sout  <= SYNC1;
        end
        PRE1: if (tick) begin
          state <= DATA;
          sout  <= shreg[DATA_W-1];
        end
        DATA: if (tick) begin
          shreg   <= shreg_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state <= PAR;
              sout  <= parity;
            end else begin
              state <= STOP;
              sout  <= LINE_IDLE;
              done  <= SINGLE_CLK;
            end
          end else begin
            sout <= shreg_next[DATA_W-1];
          end
        end
        PAR: if (tick) begin
          state <= STOP;
          sout  <= LINE_IDLE;
          done  <= SINGLE_CLK;
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            done <= pre_tick;
          end
        end
        default: begin
          state <= IDLE;
          sout  <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: two configurations against a frame-level queue model.
module tb_pattern_tx;

  typedef logic [1:0] sym_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       ready_a, sout_a, busy_a, done_a;
  logic       ready_b, sout_b, busy_b, done_b;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  sym_q_t q_a, q_b;
  logic   rec_s[$];
  logic   rec_d[$];

  always #5 clk = ~clk;

  pattern_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .valid(valid_a), .data(data_a),
    .ready(ready_a), .sout(sout_a), .busy(busy_a), .done(done_a)
  );

  pattern_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .valid(valid_b), .data(data_b),
    .ready(ready_b), .sout(sout_b), .busy(busy_b), .done(done_b)
  );

  // Each element is {done, sout} for one clock of the frame
  function automatic sym_q_t build_frame(input logic [7:0] d, input int clks, input bit par_en);
    sym_q_t f;
    logic   bits[$];
    int     ones = 0;
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (par_en) bits.push_back(logic'(ones % 2));
    bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < clks; c++) f.push_back({1'b0, bits[i]});
    f[f.size()-1][1] = 1'b1;
    return f;
  endfunction

  function automatic logic [63:0] pack_sout(input sym_q_t f);
    logic [63:0] v = '0;
    foreach (f[i]) v = {v[62:0], f[i][0]};
    return v;
  endfunction

  function automatic logic [63:0] pack_rec(input logic r[$]);
    logic [63:0] v = '0;
    foreach (r[i]) v = {v[62:0], r[i]};
    return v;
  endfunction

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (q_a.size() != 0) void'(q_a.pop_front());
      else if (valid_a) q_a = build_frame(data_a, 1, 1'b1);
      if (q_b.size() != 0) void'(q_b.pop_front());
      else if (valid_b) q_b = build_frame(data_b, 3, 1'b0);
    end
  end

  task automatic check_output();
    logic [1:0] ea, eb;
    logic       ba, bb;
    ba = (q_a.size() != 0) && !reset;
    bb = (q_b.size() != 0) && !reset;
    ea = ba ? q_a[0] : 2'b01;
    eb = bb ? q_b[0] : 2'b01;
    check_val("a_sout", 64'(sout_a), 64'(ea[0]));
    check_val("a_done", 64'(done_a), 64'(ea[1]));
    check_val("a_busy", 64'(busy_a), 64'(ba));
    check_val("a_ready", 64'(ready_a), 64'(!ba));
    check_val("b_sout", 64'(sout_b), 64'(eb[0]));
    check_val("b_done", 64'(done_b), 64'(eb[1]));
    check_val("b_busy", 64'(busy_b), 64'(bb));
    check_val("b_ready", 64'(ready_b), 64'(!bb));
  endtask

  always @(negedge clk) if (check_en) check_output();

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin valid_a = v; data_a = d; end
    else begin valid_b = v; data_b = d; end
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? ready_a : ready_b;
  endfunction

  // Presents a word, waits for acceptance, then records len frame cycles
  task automatic apply_stimulus(input int which, input logic [7:0] d, input int len,
                                input bit keep_valid, input logic [7:0] next_d);
    int n = 0;
    @(negedge clk);
    drive(which, 1'b1, d);
    while (!rdy(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    rec_s.delete();
    rec_d.delete();
    if (n >= 200) begin
      check_val("accept_wait", 64'(n), 64'(0));
      return;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) drive(which, keep_valid, next_d);
      rec_s.push_back((which == 0) ? sout_a : sout_b);
      rec_d.push_back((which == 0) ? done_a : done_b);
    end
  endtask

  initial begin
    int y_count, y_first, done_seen;
    logic prev;
    sym_q_t f;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_sout", 64'(sout_a), 64'd1);
    check_val("reset_ready", 64'(ready_a), 64'd1);
    check_val("reset_busy", 64'(busy_a), 64'd0);
    check_val("reset_done", 64'(done_a), 64'd0);
    check_en = 1'b1;
    #2 reset = 1'b0;

    f = build_frame(8'hA5, 1, 1'b1);
    check_val("model_a5_len", 64'(f.size()), 64'd12);
    check_val("model_a5_sout", pack_sout(f), 64'b011010010101);
    f = build_frame(8'hFF, 3, 1'b0);
    check_val("model_ff_len", 64'(f.size()), 64'd33);

    apply_stimulus(0, 8'hA5, 12, 1'b0, 8'hA5);
    check_val("frame_a5_sout", pack_rec(rec_s), 64'b011010010101);
    check_val("frame_a5_done", pack_rec(rec_d), 64'b000000000001);

    prev = 1'b1;
    y_count = 0;
    y_first = -1;
    foreach (rec_s[i]) begin
      if (!prev && rec_s[i]) begin
        y_count++;
        if (y_first < 0) y_first = i;
      end
      prev = rec_s[i];
    end
    check_val("loopback_count", 64'(y_count), 64'd5);
    check_val("loopback_first", 64'(y_first), 64'd1);

    apply_stimulus(1, 8'hFF, 33, 1'b0, 8'hFF);
    check_val("frame_ff_sout", pack_rec(rec_s), 64'h0_3FFF_FFFF);
    check_val("frame_ff_done", pack_rec(rec_d), 64'd1);

    apply_stimulus(0, 8'h01, 12, 1'b1, 8'h80);
    check_val("b2b_first_sout", pack_rec(rec_s), 64'b010000000111);
    @(negedge clk);
    check_val("b2b_gap", {61'd0, sout_a, busy_a, ready_a}, 64'b101);
    @(negedge clk);
    valid_a = 1'b0;
    check_val("b2b_start", {62'd0, sout_a, busy_a}, 64'b01);
    rec_s.delete();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rec_s.push_back(sout_a);
    end
    check_val("b2b_second_sout", pack_rec(rec_s), 64'b11000000011);

    apply_stimulus(0, 8'h3C, 6, 1'b0, 8'h3C);
    #2 reset = 1'b1;
    #1;
    check_val("midreset_sout", 64'(sout_a), 64'd1);
    check_val("midreset_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) done_seen++;
    end
    check_val("midreset_no_done", 64'(done_seen), 64'd0);
    apply_stimulus(0, 8'h3C, 12, 1'b0, 8'h3C);
    check_val("frame_3c_sout", pack_rec(rec_s), 64'b010011110001);
    check_val("frame_3c_done", pack_rec(rec_d), 64'd1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      valid_a = 1'($urandom_range(0, 1));
      data_a  = 8'($urandom);
      valid_b = 1'($urandom_range(0, 1));
      data_b  = 8'($urandom);
    end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (50) @(negedge clk);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
